branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 5, which sets the number of table entries (2^INDEX_BITS).
REQ-002 The block SHALL have parameter TAG_BITS, default 25, which sets the tag width and SHALL equal 30-INDEX_BITS.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port pc, input, 32 bits: the fetch-stage PC to look up.
REQ-006 The block SHALL have port pred_taken, output, 1 bit: the taken prediction for pc.
REQ-007 The block SHALL have port pred_target, output, 32 bits: the predicted next PC.
REQ-008 The block SHALL have port update_valid, input, 1 bit: a resolved branch or jump is present in EX this cycle.
REQ-009 The block SHALL have port update_pc, input, 32 bits: the PC of the resolved instruction.
REQ-010 The block SHALL have port update_taken, input, 1 bit: the resolved direction (ALU bcond_out for BRANCH; 1 for JAL/JALR).
REQ-011 The block SHALL have port update_target, input, 32 bits: the resolved taken target.
REQ-012 The block SHALL have port update_mispredict, input, 1 bit: EX detected that the fetched next PC was wrong.
REQ-013 The block SHALL have port mispredict_count, output, 32 bits: the running mispredict count.

Function
REQ-014 Each table entry SHALL hold: valid (1 bit), tag (TAG_BITS), target (32 bits) and a 2-bit saturating counter.
REQ-015 Lookup index SHALL be pc[INDEX_BITS+1:2], and lookup tag SHALL be pc[31:INDEX_BITS+2].
REQ-016 A lookup hit SHALL be defined as entry valid && entry tag == lookup tag.
REQ-017 Lookup SHALL be combinational with zero-cycle latency from pc to the outputs.
REQ-018 pred_taken SHALL equal hit && counter[1].
REQ-019 pred_target SHALL be the entry target when pred_taken=1, else pc+4 (mod 2^32).
REQ-020 The update index and tag SHALL be derived from update_pc in the same way as lookup (REQ-015).
REQ-021 Updates SHALL take effect only at a rising edge where update_valid=1 and reset=1.
REQ-022 On an update hit with update_taken=1, the counter SHALL increment, saturating at 2'b11, and target SHALL be set to update_target.
REQ-023 On an update hit with update_taken=0, the counter SHALL decrement, saturating at 2'b00, and target SHALL be unchanged.
REQ-024 On an update miss with update_taken=1, the entry SHALL be allocated or replaced: valid=1, tag written, target=update_target, counter=2'b10.
REQ-025 On an update miss with update_taken=0, no table state SHALL change.
REQ-026 When a lookup and an update hit the same index in the same cycle, the lookup SHALL see the pre-update value; the new value is visible from the next cycle.
REQ-027 mispredict_count SHALL increment by 1 on each edge with update_valid=1 && update_mispredict=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 update_mispredict SHALL be ignored when update_valid=0.
REQ-029 Counter state encoding SHALL be: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.

Reset
REQ-030 On an edge with reset=0, every entry SHALL be cleared to valid=0, counter=2'b01, tag=0, target=0, and mispredict_count SHALL be cleared to 0.
REQ-031 A reset asserted at the same edge as update_valid=1 SHALL take priority: no update and no count increment.
REQ-032 During and after reset, outputs SHALL be pred_taken=0 and pred_target=pc+4 until a taken update is allocated.

Verification
REQ-033 Reset, then pc=0x00000040 -> pred_taken=0, pred_target=0x00000044, mispredict_count=0.
REQ-034 Update pc=0x40 taken target=0x100, then lookup pc=0x40 -> pred_taken=1, pred_target=0x100; lookup pc=0xC0 (same index, different tag) -> pred_taken=0, pred_target=0xC4.
REQ-035 After REQ-034, two not-taken updates on 0x40 -> counter goes 10->01->00 and pred_taken=0; a third not-taken update keeps counter 00; one taken update -> counter 01, still not predicted taken.
REQ-036 Lookup and taken-allocate update both on pc=0x80 in one cycle -> pred_taken=0 in that cycle and pred_taken=1 in the next.
REQ-037 Three edges with update_valid=1 and update_mispredict=1, plus one edge with update_valid=0 and update_mispredict=1 -> mispredict_count=3; preloaded 0xFFFFFFFF plus one mispredict -> 0.
REQ-038 Allocate 0x40, then assert reset=0 for one edge coincident with an update -> table cleared, count 0, and pc=0x40 predicts not-taken.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from pc; updates from EX commit on the rising edge.
module branch_predictor #(
   parameter int unsigned INDEX_BITS = 5,
   parameter int unsigned TAG_BITS   = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        update_valid,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic [31:0] update_target,
   input  logic        update_mispredict,
   output logic [31:0] mispredict_count
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam int unsigned IDX_LSB = 2;
   localparam int unsigned TAG_LSB = INDEX_BITS + 2;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [1:0]          ctr_q    [ENTRIES];

   logic [31:0] mispredict_q;
   logic [31:0] mispredict_d;

   logic [INDEX_BITS-1:0] lk_idx;
   logic [TAG_BITS-1:0]   lk_tag;
   logic                  lk_hit;

   logic [INDEX_BITS-1:0] up_idx;
   logic [TAG_BITS-1:0]   up_tag;
   logic                  up_hit;

   logic                  entry_we;
   logic                  entry_valid_d;
   logic [TAG_BITS-1:0]   entry_tag_d;
   logic [31:0]           entry_target_d;
   logic [1:0]            entry_ctr_d;

   // Fetch-side lookup; reads pre-update state so same-cycle updates show next cycle.
   always_comb begin
      lk_idx      = INDEX_BITS'(pc[INDEX_BITS+1:IDX_LSB]);
      lk_tag      = TAG_BITS'(pc[31:TAG_LSB]);
      lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken  = lk_hit && ctr_q[lk_idx][1];
      pred_target = pred_taken ? target_q[lk_idx] : (pc + 32'd4);
   end

   // Next value of the single entry touched by an EX update.
   always_comb begin
      up_idx         = INDEX_BITS'(update_pc[INDEX_BITS+1:IDX_LSB]);
      up_tag         = TAG_BITS'(update_pc[31:TAG_LSB]);
      up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      entry_we       = 1'b0;
      entry_valid_d  = valid_q[up_idx];
      entry_tag_d    = tag_q[up_idx];
      entry_target_d = target_q[up_idx];
      entry_ctr_d    = ctr_q[up_idx];
      if (update_valid) begin
         if (up_hit) begin
            entry_we = 1'b1;
            if (update_taken) begin
               entry_target_d = update_target;
               if (ctr_q[up_idx] != CTR_ST) begin
                  entry_ctr_d = ctr_q[up_idx] + 2'd1;
               end
            end else if (ctr_q[up_idx] != CTR_SNT) begin
               entry_ctr_d = ctr_q[up_idx] - 2'd1;
            end
         end else if (update_taken) begin
            // Not-taken misses are never allocated, so only taken misses replace.
            entry_we       = 1'b1;
            entry_valid_d  = 1'b1;
            entry_tag_d    = up_tag;
            entry_target_d = update_target;
            entry_ctr_d    = CTR_WT;
         end
      end
   end

   always_comb begin
      mispredict_d = mispredict_q;
      if (update_valid && update_mispredict) begin
         mispredict_d = mispredict_q + 32'd1;
      end
   end

   // Table and counter state; synchronous reset wins over a coincident update.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
         mispredict_q <= '0;
      end else begin
         if (entry_we) begin
            valid_q[up_idx]  <= entry_valid_d;
            tag_q[up_idx]    <= entry_tag_d;
            target_q[up_idx] <= entry_target_d;
            ctr_q[up_idx]    <= entry_ctr_d;
         end
         mispredict_q <= mispredict_d;
      end
   end

   assign mispredict_count = mispredict_q;

endmodule
